// File: rtl/mnk_pkg.sv
// Shared types for the m,n,k game core: cell codes, FSM states and
// board index helpers.
package mnk_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   typedef enum logic [1:0] {
      WAIT_MOVE,
      CHECK,
      AI_THINK,
      GAME_OVER
   } state_t;

   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
   } rc_t;

   function automatic rc_t idx2rowcol(input int idx, input int n);
      rc_t rc;
      rc.row = 4'(idx / n);
      rc.col = 4'(idx % n);
      return rc;
   endfunction

endpackage

// File: rtl/mnk_game_core_if.sv
// Human move request channel: valid/ready handshake plus reject pulse.
interface mnk_game_core_if #(
   parameter int IW = 4
);
   logic          move_valid;
   logic [IW-1:0] move_idx;
   logic          move_ready;
   logic          move_err;

   modport master (
      output move_valid, move_idx,
      input  move_ready, move_err
   );

   modport slave (
      input  move_valid, move_idx,
      output move_ready, move_err
   );
endinterface

// File: rtl/mnk_line_check.sv
// Win detector: bounded run lengths through the last move in the
// row, column, diagonal and anti-diagonal directions.
module mnk_line_check
   import mnk_pkg::*;
#(
   parameter int N  = 3,
   parameter int K  = 3,
   parameter int IW = $clog2(N*N)
) (
   input  logic [2*N*N-1:0] board,
   input  logic [IW-1:0]    last_idx,
   input  logic [1:0]       player,
   output logic             win_hit
);

   rc_t rc;
   assign rc = idx2rowcol(int'(last_idx), N);

   always_comb begin
      int  r, c, run, dr, dc, sg;
      bit  live;
      win_hit = 1'b0;
      for (int d = 0; d < 4; d++) begin
         dr  = (d == 0) ? 0 : 1;
         dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
         run = 1;
         for (int s = 0; s < 2; s++) begin
            sg   = (s == 0) ? -1 : 1;
            live = 1'b1;
            // walk outward; stop at first foreign cell or board edge
            for (int k = 1; k < K; k++) begin
               r = int'(rc.row) + sg*k*dr;
               c = int'(rc.col) + sg*k*dc;
               if (!live || r < 0 || r >= N || c < 0 || c >= N)
                  live = 1'b0;
               else if (board[2*(r*N+c) +: 2] != player)
                  live = 1'b0;
               if (live)
                  run = run + 1;
            end
         end
         if (run >= K)
            win_hit = 1'b1;
      end
   end

endmodule

// File: rtl/mnk_game_core.sv
// N x N, K-in-a-row game engine: board, turn order, win/tie detection
// and a first-free-cell computer opponent for player 2.
module mnk_game_core
   import mnk_pkg::*;
#(
   parameter int N        = 3,
   parameter int K        = 3,
   parameter int AI_DELAY = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            new_game,
   input  logic            game_mode,
   mnk_game_core_if.slave  mv,
   output logic [2*N*N-1:0] cell_state,
   output logic            p1_turn,
   output logic            p2_turn,
   output logic            p1_win,
   output logic            p2_win,
   output logic            tie,
   output logic            busy
);

   localparam int IW = $clog2(N*N);
   localparam int NC = N*N;

   state_t            state_q, state_d;
   logic [2*NC-1:0]   board_q, board_d;
   logic              turn_q, turn_d;
   logic              mode_q, mode_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [IW-1:0]     last_q, last_d;
   logic              w1_q, w1_d, w2_q, w2_d;
   logic              tie_q, tie_d, err_q, err_d;

   logic              win_hit, full, ready;
   logic              in_rng, legal;
   int                midx;
   logic [IW-1:0]     free_idx;
   logic [1:0]        mover;

   assign mover = turn_q ? CELL_P2 : CELL_P1;

   mnk_line_check #(
      .N  (N),
      .K  (K),
      .IW (IW)
   ) u_line (
      .board    (board_q),
      .last_idx (last_q),
      .player   (mover),
      .win_hit  (win_hit)
   );

   // lowest empty cell wins, so scan from the top down
   always_comb begin
      full     = 1'b1;
      free_idx = '0;
      for (int i = NC-1; i >= 0; i--) begin
         if (board_q[2*i +: 2] == CELL_EMPTY) begin
            full     = 1'b0;
            free_idx = IW'(i);
         end
      end
   end

   always_comb begin
      in_rng = int'(mv.move_idx) < NC;
      midx   = in_rng ? int'(mv.move_idx) : 0;
      legal  = in_rng &&
               (board_q[2*midx +: 2] == CELL_EMPTY);
   end

   assign ready = (state_q == WAIT_MOVE) &&
                  !(mode_q && turn_q);

   always_comb begin
      state_d = state_q;
      board_d = board_q;
      turn_d  = turn_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      tie_d   = tie_q;
      err_d   = 1'b0;
      if (new_game) begin
         state_d = WAIT_MOVE;
         board_d = '0;
         turn_d  = 1'b0;
         mode_d  = game_mode;
         cnt_d   = '0;
         last_d  = '0;
         w1_d    = 1'b0;
         w2_d    = 1'b0;
         tie_d   = 1'b0;
      end else begin
         unique case (state_q)
            WAIT_MOVE: begin
               if (mv.move_valid && ready) begin
                  if (legal) begin
                     board_d[2*midx +: 2] = mover;
                     last_d  = IW'(midx);
                     state_d = CHECK;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            CHECK: begin
               if (win_hit) begin
                  w1_d    = !turn_q;
                  w2_d    = turn_q;
                  state_d = GAME_OVER;
               end else if (full) begin
                  tie_d   = 1'b1;
                  state_d = GAME_OVER;
               end else begin
                  turn_d = !turn_q;
                  if (mode_q && !turn_q) begin
                     cnt_d   = 8'(AI_DELAY);
                     state_d = AI_THINK;
                  end else begin
                     state_d = WAIT_MOVE;
                  end
               end
            end
            AI_THINK: begin
               if (cnt_q <= 8'd1) begin
                  board_d[2*int'(free_idx) +: 2] = CELL_P2;
                  last_d  = free_idx;
                  cnt_d   = '0;
                  state_d = CHECK;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            GAME_OVER: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= WAIT_MOVE;
         board_q <= '0;
         turn_q  <= 1'b0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         last_q  <= '0;
         w1_q    <= 1'b0;
         w2_q    <= 1'b0;
         tie_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         turn_q  <= turn_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         tie_q   <= tie_d;
         err_q   <= err_d;
      end
   end

   assign mv.move_ready = ready;
   assign mv.move_err   = err_q;
   assign cell_state    = board_q;
   assign p1_win        = w1_q;
   assign p2_win        = w2_q;
   assign tie           = tie_q;
   assign busy          = (state_q == CHECK) ||
                          (state_q == AI_THINK);
   assign p1_turn = ((state_q == WAIT_MOVE) ||
                     (state_q == AI_THINK)) && !turn_q;
   assign p2_turn = ((state_q == WAIT_MOVE) ||
                     (state_q == AI_THINK)) && turn_q;

   a_one_result: assert property (@(posedge clk) disable iff (!reset)
      $onehot0({p1_win, p2_win, tie}));

endmodule

// File: tb/tb_mnk_game_core.sv
// Bench for mnk_game_core: 3x3/K3 and 5x5/K4 instances checked every
// cycle against a board-level game model, plus directed games.
module tb_mnk_game_core;

   localparam int NA  = 3;
   localparam int KA  = 3;
   localparam int DA  = 4;
   localparam int NB  = 5;
   localparam int KB  = 4;
   localparam int DB  = 2;
   localparam int IWA = $clog2(NA*NA);
   localparam int IWB = $clog2(NB*NB);

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic new_game = 1'b0;
   logic game_mode = 1'b0;
   logic valid = 1'b0;
   logic sel = 1'b0;
   logic [5:0] idx = '0;

   mnk_game_core_if #(.IW(IWA)) ia();
   mnk_game_core_if #(.IW(IWB)) ib();

   logic [2*NA*NA-1:0] cs_a;
   logic [2*NB*NB-1:0] cs_b;
   logic a_p1t, a_p2t, a_w1, a_w2, a_tie, a_busy;
   logic b_p1t, b_p2t, b_w1, b_w2, b_tie, b_busy;

   assign ia.move_valid = valid & ~sel;
   assign ia.move_idx   = idx[IWA-1:0];
   assign ib.move_valid = valid & sel;
   assign ib.move_idx   = idx[IWB-1:0];

   mnk_game_core #(.N(NA), .K(KA), .AI_DELAY(DA)) u_a (
      .clk(clk), .reset(reset), .new_game(new_game),
      .game_mode(game_mode), .mv(ia), .cell_state(cs_a),
      .p1_turn(a_p1t), .p2_turn(a_p2t), .p1_win(a_w1),
      .p2_win(a_w2), .tie(a_tie), .busy(a_busy)
   );

   mnk_game_core #(.N(NB), .K(KB), .AI_DELAY(DB)) u_b (
      .clk(clk), .reset(reset), .new_game(new_game),
      .game_mode(game_mode), .mv(ib), .cell_state(cs_b),
      .p1_turn(b_p1t), .p2_turn(b_p2t), .p1_win(b_w1),
      .p2_win(b_w2), .tie(b_tie), .busy(b_busy)
   );

   always #5 clk = ~clk;

   logic [49:0] cs;
   logic [7:0]  st;
   assign cs = sel ? cs_b : {32'd0, cs_a};
   assign st = sel ?
      {ib.move_ready, ib.move_err, b_p1t, b_p2t,
       b_w1, b_w2, b_tie, b_busy} :
      {ia.move_ready, ia.move_err, a_p1t, a_p2t,
       a_w1, a_w2, a_tie, a_busy};

   wire rdy  = st[7];
   wire err  = st[6];
   wire p1t  = st[5];
   wire p2t  = st[4];
   wire w1   = st[3];
   wire w2   = st[2];
   wire tie  = st[1];
   wire busy = st[0];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(string nm, logic [63:0] act,
                      logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // game model: phase 0 await move, 1 judge, 2 computer, 3 over
   int mb[25];
   int ph, turn, mode, ai_at, cyc;
   bit e_err, e_w1, e_w2, e_tie;

   function automatic int gn();
      return sel ? NB : NA;
   endfunction

   function automatic bit has_line(int p);
      int n, k, rr, cc;
      bit ok;
      int dr[4];
      int dc[4];
      n  = gn();
      k  = sel ? KB : KA;
      dr = '{0, 1, 1, 1};
      dc = '{1, 0, 1, -1};
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            for (int d = 0; d < 4; d++) begin
               ok = 1'b1;
               for (int s = 0; s < k; s++) begin
                  rr = r + s*dr[d];
                  cc = c + s*dc[d];
                  if (rr < 0 || rr >= n || cc < 0 || cc >= n)
                     ok = 1'b0;
                  else if (mb[rr*n+cc] != p)
                     ok = 1'b0;
               end
               if (ok) return 1'b1;
            end
      return 1'b0;
   endfunction

   function automatic int free_cell();
      for (int i = 0; i < gn()*gn(); i++)
         if (mb[i] == 0) return i;
      return -1;
   endfunction

   function automatic bit m_ready();
      return ph == 0 && !(mode == 1 && turn == 2);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 25; i++) mb[i] = 0;
      ph = 0; turn = 1; ai_at = -1;
      e_err = 0; e_w1 = 0; e_w2 = 0; e_tie = 0;
   endtask

   task automatic model_step();
      int li, fc;
      if (!reset) begin
         model_clear();
         mode = 0;
      end else if (new_game) begin
         model_clear();
         mode = int'(game_mode);
      end else begin
         e_err = 0;
         case (ph)
            0: if (valid && m_ready()) begin
               li = sel ? int'(idx[4:0]) : int'(idx[3:0]);
               if (li < gn()*gn() && mb[li] == 0) begin
                  mb[li] = turn;
                  ph = 1;
               end else e_err = 1;
            end
            1: if (has_line(turn)) begin
               if (turn == 1) e_w1 = 1; else e_w2 = 1;
               ph = 3;
            end else if (free_cell() < 0) begin
               e_tie = 1;
               ph = 3;
            end else begin
               turn = 3 - turn;
               if (mode == 1 && turn == 2) begin
                  ai_at = cyc + (sel ? DB : DA);
                  ph = 2;
               end else ph = 0;
            end
            2: if (cyc == ai_at) begin
               fc = free_cell();
               if (fc >= 0) mb[fc] = 2;
               ph = 1;
            end
            default: ;
         endcase
      end
      cyc++;
   endtask

   function automatic logic [7:0] exp_st();
      bit play;
      play = (ph == 0 || ph == 2);
      return {m_ready(), e_err, play && turn == 1,
              play && turn == 2, e_w1, e_w2, e_tie,
              ph == 1 || ph == 2};
   endfunction

   function automatic logic [49:0] exp_cs();
      logic [49:0] v;
      v = '0;
      for (int i = 0; i < gn()*gn(); i++)
         v[2*i +: 2] = 2'(mb[i]);
      return v;
   endfunction

   initial cyc = 0;

   always @(posedge clk) begin
      model_step();
      #1;
      chk("status", st, exp_st());
      chk("board", cs, exp_cs());
   end

   task automatic wait_ready();
      int t;
      t = 0;
      while (!rdy && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("wait_ready", rdy, 1);
   endtask

   task automatic mv(int i);
      wait_ready();
      valid = 1'b1;
      idx   = 6'(i);
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic ng(bit gm);
      @(negedge clk);
      new_game  = 1'b1;
      game_mode = gm;
      @(negedge clk);
      new_game  = 1'b0;
   endtask

   task automatic busy_len(output int nb);
      nb = 0;
      while (busy && nb < 30) begin
         nb++;
         @(negedge clk);
      end
   endtask

   task automatic rand_run(int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         new_game  = ($urandom_range(0, 39) == 0);
         game_mode = 1'($urandom_range(0, 1));
         valid     = 1'($urandom_range(0, 1));
         idx = sel ? 6'($urandom_range(0, 31)) :
                     6'($urandom_range(0, 15));
      end
      @(negedge clk);
      new_game = 1'b0;
      valid    = 1'b0;
   endtask

   task automatic hard_reset(bit s);
      @(negedge clk);
      reset = 1'b0;
      sel   = s;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   int seq_tie[9]  = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
   int seq_last[9] = '{0, 1, 2, 3, 5, 4, 7, 6, 8};
   int nb;

   initial begin
      hard_reset(1'b0);
      chk("rst_board", cs, 0);
      chk("rst_p1turn", p1t, 1);
      chk("rst_ready", rdy, 1);
      chk("rst_flags", {w1, w2, tie, busy, p2t, err}, 0);

      ng(1'b0);
      mv(0); mv(3); mv(1); mv(4); mv(2);
      @(negedge clk);
      chk("row_win", w1, 1);
      chk("row_cells", cs[5:0], 6'b010101);
      chk("row_ready", rdy, 0);
      chk("row_turns", {p1t, p2t}, 0);

      ng(1'b0);
      mv(0); mv(0);
      chk("occ_err", err, 1);
      chk("occ_turn", p2t, 1);
      chk("occ_board", cs[17:0], 18'd1);
      mv(9);
      chk("rng_err", err, 1);
      @(negedge clk);
      chk("err_once", err, 0);
      chk("rng_board", cs[17:0], 18'd1);
      chk("rng_turn", p2t, 1);

      ng(1'b0);
      for (int i = 0; i < 9; i++) mv(seq_tie[i]);
      @(negedge clk);
      chk("tie", {w1, w2, tie}, 3'b001);

      ng(1'b0);
      for (int i = 0; i < 9; i++) mv(seq_last[i]);
      @(negedge clk);
      chk("last_win", {w1, w2, tie}, 3'b100);

      ng(1'b1);
      mv(4);
      busy_len(nb);
      chk("ai_busy", nb, 1 + DA + 1);
      chk("ai_cell0", cs[1:0], 2'b10);
      chk("ai_cell4", cs[9:8], 2'b01);
      chk("ai_back", {rdy, p1t}, 2'b11);

      ng(1'b1);
      mv(4);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ai_board", cs, 0);
      chk("rst_ai_turn", p1t, 1);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst_ai_stale", cs, 0);

      ng(1'b1);
      mv(4);
      new_game  = 1'b1;
      game_mode = 1'b1;
      @(negedge clk);
      new_game  = 1'b0;
      chk("ng_chk_board", cs, 0);
      chk("ng_chk_turn", {rdy, p1t}, 2'b11);
      repeat (8) @(negedge clk);
      chk("ng_chk_stale", cs, 0);

      rand_run(1500);

      hard_reset(1'b1);
      chk("b_rst_board", cs, 0);
      ng(1'b0);
      mv(4); mv(0); mv(8); mv(1); mv(12); mv(2);
      @(negedge clk);
      chk("b_k3_nowin", {w1, w2, tie}, 0);
      mv(16);
      @(negedge clk);
      chk("b_adiag_win", {w1, w2, tie}, 3'b100);
      chk("b_cell16", cs[33:32], 2'b01);

      ng(1'b0);
      mv(3); mv(15); mv(4); mv(20); mv(5); mv(22); mv(6);
      @(negedge clk);
      chk("b_wrap_nowin", {w1, w2, tie}, 0);
      chk("b_wrap_turn", {p1t, p2t}, 2'b01);

      ng(1'b1);
      mv(12);
      busy_len(nb);
      chk("b_ai_busy", nb, 1 + DB + 1);
      chk("b_ai_cell0", cs[1:0], 2'b10);

      rand_run(1500);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
